// File: rtl/data_mem_ctrl.sv
// -----------------------------------------------------------------------------
// data_mem_ctrl
//   L1 data memory for the RV32 datapath. Byte-addressed, DEPTH x 32-bit words,
//   one outstanding request, fixed response latency LAT (1..4 cycles).
//   Handles RV32I load/store sizes with byte-lane steering, sign/zero extension
//   and fault detection (misaligned, out of range, illegal funct3).
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   req_valid    request present
//   req_ready    request can be accepted this cycle
//   req_we       1 = store, 0 = load
//   req_addr     byte address
//   req_funct3   RV32I size/sign code (000 B, 001 H, 010 W, 100 BU, 101 HU)
//   req_wdata    right-aligned store data
//   resp_valid   one-cycle response pulse
//   resp_rdata   formatted load data (0 for stores/faults), held between pulses
//   resp_err     access faulted, held between pulses
//
// State  | meaning
// -------+--------------------------------------------------------------
// S_IDLE | waiting for a request, req_ready=1
// S_BUSY | latency countdown, req_ready=0, inputs ignored
// S_RESP | resp_valid=1 for one cycle, req_ready=1 (back-to-back allowed)
// -----------------------------------------------------------------------------
module data_mem_ctrl #(
  parameter int DEPTH = 1024,
  parameter int LAT   = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(LAT) + 1;
  // BUSY lasts LAT-1 cycles; the counter reaches zero in the last of them.
  localparam logic [CW-1:0] CNT_LOAD = CW'((LAT > 1) ? LAT - 2 : 0);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam state_t S_AFTER_ACCEPT = (LAT > 1) ? S_BUSY : S_RESP;

  state_t          r_state;
  state_t          w_next;
  logic [CW-1:0]   r_cnt;
  logic            w_accept;

  logic [AW-1:0]   w_idx;
  logic            w_oor;
  logic            w_bad_f3;
  logic            w_misal;
  logic            w_err;
  logic [3:0]      w_be;
  logic [31:0]     w_wbytes;
  logic            w_wr_en;

  logic [31:0]     r_mem [DEPTH];

  logic [31:0]     r_word;
  logic [1:0]      r_lane;
  logic [2:0]      r_f3;
  logic            r_load_ok;
  logic            r_err;

  logic [31:0]     w_shift;
  logic [7:0]      w_byte;
  logic [15:0]     w_half;
  logic [31:0]     w_fmt;

  // ---------------------------------------------------------------------------
  // Handshake / FSM
  // ---------------------------------------------------------------------------
  assign req_ready  = (r_state != S_BUSY);
  assign resp_valid = (r_state == S_RESP);
  assign w_accept   = req_valid && req_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = S_AFTER_ACCEPT;
      S_BUSY:  if (r_cnt == '0) w_next = S_RESP;
      S_RESP:  w_next = w_accept ? S_AFTER_ACCEPT : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Reloaded on every acceptance, so it never needs to wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_accept) begin
      r_cnt <= CNT_LOAD;
    end else if (r_state == S_BUSY && r_cnt != '0) begin
      r_cnt <= r_cnt - CW'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Request decode and fault detection
  // ---------------------------------------------------------------------------
  assign w_idx = req_addr[AW+1:2];
  assign w_oor = (req_addr[31:2] >= 30'(DEPTH));

  always_comb begin
    w_bad_f3 = 1'b0;
    if (req_we) begin
      w_bad_f3 = !(req_funct3 inside {3'b000, 3'b001, 3'b010});
    end else begin
      w_bad_f3 = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11);
    end
  end

  assign w_misal = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                   ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
  assign w_err   = w_bad_f3 || w_misal || w_oor;

  // Store data is replicated across lanes so the byte enables pick the slot.
  always_comb begin
    w_be     = 4'b0000;
    w_wbytes = req_wdata;
    case (req_funct3[1:0])
      2'b00: begin
        w_be     = 4'b0001 << req_addr[1:0];
        w_wbytes = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        w_be     = req_addr[1] ? 4'b1100 : 4'b0011;
        w_wbytes = {2{req_wdata[15:0]}};
      end
      2'b10:   w_be = 4'b1111;
      default: w_be = 4'b0000;
    endcase
  end

  assign w_wr_en = w_accept && req_we && !w_err;

  // ---------------------------------------------------------------------------
  // Memory array (never cleared by reset)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wbytes[8*b +: 8];
      end
    end
  end

  // Word and request attributes are captured at acceptance; the word is the
  // pre-write value, which is irrelevant since a store returns no data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_word    <= '0;
      r_lane    <= '0;
      r_f3      <= '0;
      r_load_ok <= 1'b0;
      r_err     <= 1'b0;
    end else if (w_accept) begin
      r_word    <= r_mem[w_idx];
      r_lane    <= req_addr[1:0];
      r_f3      <= req_funct3;
      r_load_ok <= !req_we && !w_err;
      r_err     <= w_err;
    end
  end

  // ---------------------------------------------------------------------------
  // Load formatting
  // ---------------------------------------------------------------------------
  assign w_shift = r_word >> {r_lane, 3'b000};
  assign w_byte  = w_shift[7:0];
  assign w_half  = r_lane[1] ? r_word[31:16] : r_word[15:0];

  always_comb begin
    w_fmt = '0;
    if (r_load_ok) begin
      case (r_f3)
        3'b000:  w_fmt = {{24{w_byte[7]}}, w_byte};
        3'b001:  w_fmt = {{16{w_half[15]}}, w_half};
        3'b010:  w_fmt = r_word;
        3'b100:  w_fmt = {24'd0, w_byte};
        3'b101:  w_fmt = {16'd0, w_half};
        default: w_fmt = '0;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Response registers
  // With LAT=1 the capture registers only change on the acceptance that starts
  // the response, so they already hold between pulses. With LAT>1 a second
  // stage loads on the BUSY->RESP transition so nothing moves during BUSY.
  // ---------------------------------------------------------------------------
  if (LAT == 1) begin : g_direct
    assign resp_rdata = w_fmt;
    assign resp_err   = r_err;
  end else begin : g_held
    logic [31:0] r_rdata;
    logic        r_rerr;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_rdata <= '0;
        r_rerr  <= 1'b0;
      end else if (r_state == S_BUSY && r_cnt == '0) begin
        r_rdata <= w_fmt;
        r_rerr  <= r_err;
      end
    end

    assign resp_rdata = r_rdata;
    assign resp_err   = r_rerr;
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
module tb_data_mem_ctrl;

  localparam int D0 = 1024;
  localparam int L0 = 1;
  localparam int D1 = 64;
  localparam int L1 = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        vld0 = 1'b0, we0 = 1'b0, rdy0, rv0, er0;
  logic [31:0] a0 = '0, wd0 = '0, rd0;
  logic [2:0]  f0 = '0;
  logic        vld1 = 1'b0, we1 = 1'b0, rdy1, rv1, er1;
  logic [31:0] a1 = '0, wd1 = '0, rd1;
  logic [2:0]  f1 = '0;

  data_mem_ctrl u_dut0 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(vld0), .req_ready(rdy0), .req_we(we0), .req_addr(a0),
    .req_funct3(f0), .req_wdata(wd0),
    .resp_valid(rv0), .resp_rdata(rd0), .resp_err(er0)
  );

  data_mem_ctrl #(.DEPTH(D1), .LAT(L1)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(vld1), .req_ready(rdy1), .req_we(we1), .req_addr(a1),
    .req_funct3(f1), .req_wdata(wd1),
    .resp_valid(rv1), .resp_rdata(rd1), .resp_err(er1)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // Reference: flat byte memory per instance plus last response seen.
  logic [7:0]  mm [2][4096];
  logic [31:0] last_rd [2];
  logic        last_er [2];

  function automatic logic f_rdy(input int s); return (s == 1) ? rdy1 : rdy0; endfunction
  function automatic logic f_rv (input int s); return (s == 1) ? rv1  : rv0;  endfunction
  function automatic logic f_er (input int s); return (s == 1) ? er1  : er0;  endfunction
  function automatic logic [31:0] f_rd(input int s); return (s == 1) ? rd1 : rd0; endfunction
  function automatic int f_lat(input int s); return (s == 1) ? L1 : L0; endfunction
  function automatic int f_depth(input int s); return (s == 1) ? D1 : D0; endfunction

  function automatic void model(input int sel, input logic we, input logic [31:0] a,
                                input logic [2:0] f3, input logic [31:0] wd,
                                output logic [31:0] rd, output logic err);
    longint depth;
    int     size;
    logic   bad;
    longint v;
    depth = f_depth(sel);
    if (we) bad = !(f3 inside {3'd0, 3'd1, 3'd2});
    else    bad = !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    case (f3)
      3'd0, 3'd4: size = 1;
      3'd1, 3'd5: size = 2;
      default:    size = 4;
    endcase
    err = bad || ((int'(a[1:0]) % size) != 0) || ((longint'({32'd0, a}) / 4) >= depth);
    rd = '0;
    if (!err) begin
      if (we) begin
        for (int i = 0; i < size; i++) mm[sel][int'(a) + i] = wd[8*i +: 8];
      end else begin
        v = 0;
        for (int i = 0; i < size; i++) v = v + (longint'(mm[sel][int'(a) + i]) << (8*i));
        if (!f3[2] && size < 4 && v >= (longint'(1) << (8*size - 1)))
          v = v - (longint'(1) << (8*size));
        rd = v[31:0];
      end
    end
  endfunction

  task automatic drive(input int sel, input logic v, input logic we, input logic [31:0] a,
                       input logic [2:0] f3, input logic [31:0] wd);
    if (sel == 1) begin
      vld1 = v; we1 = we; a1 = a; f1 = f3; wd1 = wd;
    end else begin
      vld0 = v; we0 = we; a0 = a; f0 = f3; wd0 = wd;
    end
  endtask

  // Called just after a negedge; returns just after the negedge where the
  // response pulse is observed, so a following call issues back-to-back.
  task automatic xfer(input int sel, input logic we, input logic [31:0] a,
                      input logic [2:0] f3, input logic [31:0] wd,
                      output logic [31:0] got_rd, output logic got_er);
    logic [31:0] exp_rd;
    logic        exp_er;
    int          k;
    drive(sel, 1'b1, we, a, f3, wd);
    n_chk++;
    if (f_rdy(sel) !== 1'b1)
      $display("FAIL ready_before_accept dut%0d: got %b want 1", sel, f_rdy(sel));
    else n_pass++;
    @(posedge clk);
    model(sel, we, a, f3, wd, exp_rd, exp_er);
    k = 0;
    while (k < f_lat(sel) + 4) begin
      @(negedge clk);
      k++;
      if (k == 1) drive(sel, 1'b0, 1'b0, '0, '0, '0);
      if (f_rv(sel) === 1'b1) break;
      n_chk++;
      if (f_rdy(sel) !== 1'b0 || f_rd(sel) !== last_rd[sel] || f_er(sel) !== last_er[sel])
        $display("FAIL busy_hold dut%0d k=%0d: got rdy=%b rd=%h err=%b want rdy=0 rd=%h err=%b",
                 sel, k, f_rdy(sel), f_rd(sel), f_er(sel), last_rd[sel], last_er[sel]);
      else n_pass++;
    end
    n_chk++;
    if (f_rv(sel) !== 1'b1 || k != f_lat(sel))
      $display("FAIL latency dut%0d: got %0d cycles (valid=%b) want %0d", sel, k, f_rv(sel), f_lat(sel));
    else n_pass++;
    n_chk++;
    if (f_rd(sel) !== exp_rd || f_er(sel) !== exp_er)
      $display("FAIL resp dut%0d we=%b a=%h f3=%b: got rd=%h err=%b want rd=%h err=%b",
               sel, we, a, f3, f_rd(sel), f_er(sel), exp_rd, exp_er);
    else n_pass++;
    n_chk++;
    if (f_rdy(sel) !== 1'b1)
      $display("FAIL ready_in_resp dut%0d: got %b want 1", sel, f_rdy(sel));
    else n_pass++;
    last_rd[sel] = exp_rd;
    last_er[sel] = exp_er;
    got_rd = f_rd(sel);
    got_er = f_er(sel);
  endtask

  task automatic gap(input int sel);
    @(negedge clk);
    n_chk++;
    if (f_rv(sel) !== 1'b0 || f_rd(sel) !== last_rd[sel] || f_er(sel) !== last_er[sel])
      $display("FAIL idle_hold dut%0d: got valid=%b rd=%h err=%b want valid=0 rd=%h err=%b",
               sel, f_rv(sel), f_rd(sel), f_er(sel), last_rd[sel], last_er[sel]);
    else n_pass++;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      n_chk++;
      if (f_rdy(s) !== 1'b1) $display("FAIL reset_ready dut%0d: got %b want 1", s, f_rdy(s));
      else n_pass++;
      n_chk++;
      if (f_rv(s) !== 1'b0) $display("FAIL reset_valid dut%0d: got %b want 0", s, f_rv(s));
      else n_pass++;
      n_chk++;
      if (f_rd(s) !== 32'd0) $display("FAIL reset_rdata dut%0d: got %h want 0", s, f_rd(s));
      else n_pass++;
      n_chk++;
      if (f_er(s) !== 1'b0) $display("FAIL reset_err dut%0d: got %b want 0", s, f_er(s));
      else n_pass++;
      last_rd[s] = '0;
      last_er[s] = 1'b0;
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_store_load();
    logic [31:0] rd; logic er;
    xfer(0, 1'b1, 32'h10, 3'b010, 32'hDEADBEEF, rd, er); gap(0);
    xfer(0, 1'b0, 32'h10, 3'b010, 32'h0, rd, er);
    n_chk++;
    if (rd !== 32'hDEADBEEF || er !== 1'b0)
      $display("FAIL lw_basic: got %h err=%b want deadbeef err=0", rd, er);
    else n_pass++;
    gap(0);
  endtask

  task automatic test_byte();
    logic [31:0] rd; logic er;
    xfer(0, 1'b1, 32'h11, 3'b000, 32'h80, rd, er); gap(0);
    xfer(0, 1'b0, 32'h11, 3'b000, 32'h0, rd, er);
    n_chk++;
    if (rd !== 32'hFFFFFF80) $display("FAIL lb: got %h want ffffff80", rd); else n_pass++;
    xfer(0, 1'b0, 32'h11, 3'b100, 32'h0, rd, er);
    n_chk++;
    if (rd !== 32'h00000080) $display("FAIL lbu: got %h want 00000080", rd); else n_pass++;
    xfer(0, 1'b0, 32'h10, 3'b010, 32'h0, rd, er);
    n_chk++;
    if (rd !== 32'hDEAD80EF) $display("FAIL lw_after_sb: got %h want dead80ef", rd); else n_pass++;
    gap(0);
  endtask

  task automatic test_half();
    logic [31:0] rd; logic er;
    xfer(0, 1'b1, 32'h12, 3'b001, 32'h8001, rd, er); gap(0);
    xfer(0, 1'b0, 32'h12, 3'b001, 32'h0, rd, er);
    n_chk++;
    if (rd !== 32'hFFFF8001) $display("FAIL lh: got %h want ffff8001", rd); else n_pass++;
    xfer(0, 1'b0, 32'h12, 3'b101, 32'h0, rd, er);
    n_chk++;
    if (rd !== 32'h00008001) $display("FAIL lhu: got %h want 00008001", rd); else n_pass++;
    xfer(0, 1'b0, 32'h10, 3'b010, 32'h0, rd, er);
    n_chk++;
    if (rd !== 32'h800180EF) $display("FAIL lw_after_sh: got %h want 800180ef", rd); else n_pass++;
    gap(0);
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic er;
    logic        we_t [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [31:0] a_t  [5] = '{32'h13, 32'h11, 32'(4*D0), 32'h10, 32'h10};
    logic [2:0]  f_t  [5] = '{3'b010, 3'b001, 3'b010, 3'b100, 3'b011};
    for (int i = 0; i < 5; i++) begin
      xfer(0, we_t[i], a_t[i], f_t[i], 32'hFFFFFFFF, rd, er);
      n_chk++;
      if (er !== 1'b1 || rd !== 32'd0)
        $display("FAIL fault_%0d: got err=%b rd=%h want err=1 rd=0", i, er, rd);
      else n_pass++;
      gap(0);
    end
    xfer(0, 1'b0, 32'h10, 3'b010, 32'h0, rd, er);
    n_chk++;
    if (rd !== 32'h800180EF || er !== 1'b0)
      $display("FAIL mem_unchanged: got %h err=%b want 800180ef err=0", rd, er);
    else n_pass++;
    gap(0);
  endtask

  task automatic test_random(input int sel, input int nw, input int n);
    logic [31:0] rd, a; logic er, we; logic [2:0] f3;
    int r;
    for (int w = 0; w < nw; w++) xfer(sel, 1'b1, 32'(4*w), 3'b010, $urandom, rd, er);
    gap(sel);
    for (int i = 0; i < n; i++) begin
      r  = $urandom_range(0, 15);
      we = 1'($urandom_range(0, 1));
      if (r == 0) f3 = 3'($urandom_range(0, 7));
      else case ($urandom_range(0, 4))
        0: f3 = 3'b000; 1: f3 = 3'b001; 2: f3 = 3'b010; 3: f3 = 3'b100; default: f3 = 3'b101;
      endcase
      if (r == 1)      a = 32'(4*f_depth(sel) + $urandom_range(0, 4095));
      else if (r == 2) a = $urandom | 32'h8000_0000;
      else             a = 32'($urandom_range(0, 4*nw - 1));
      xfer(sel, we, a, f3, $urandom, rd, er);
      if ($urandom_range(0, 2) != 0) gap(sel);
    end
    gap(sel);
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd; logic er; logic [31:0] d;
    d = $urandom;
    xfer(1, 1'b1, 32'h40, 3'b010, d, rd, er);
    xfer(1, 1'b0, 32'h40, 3'b010, 32'h0, rd, er);
    n_chk++;
    if (rd !== d) $display("FAIL b2b_load: got %h want %h", rd, d); else n_pass++;
    xfer(1, 1'b0, 32'h41, 3'b000, 32'h0, rd, er);
    xfer(1, 1'b0, 32'h42, 3'b101, 32'h0, rd, er);
    xfer(1, 1'b0, 32'h43, 3'b001, 32'h0, rd, er);
    xfer(0, 1'b1, 32'h20, 3'b001, 32'hBEEF, rd, er);
    xfer(0, 1'b0, 32'h20, 3'b001, 32'h0, rd, er);
    n_chk++;
    if (rd !== 32'hFFFFBEEF) $display("FAIL b2b_lat1: got %h want ffffbeef", rd); else n_pass++;
    gap(0);
    gap(1);
  endtask

  task automatic test_reset_busy();
    logic [31:0] rd, exp_rd; logic er, exp_er, seen; logic [31:0] d;
    d = $urandom;
    drive(1, 1'b1, 1'b1, 32'h20, 3'b010, d);
    @(posedge clk);
    model(1, 1'b1, 32'h20, 3'b010, d, exp_rd, exp_er);
    @(negedge clk);
    drive(1, 1'b0, 1'b0, '0, '0, '0);
    rst_n = 1'b0;
    #1;
    n_chk++;
    if (rdy1 !== 1'b1 || rv1 !== 1'b0 || rd1 !== 32'd0 || er1 !== 1'b0)
      $display("FAIL reset_in_busy: got rdy=%b valid=%b rd=%h err=%b want 1 0 0 0", rdy1, rv1, rd1, er1);
    else n_pass++;
    for (int s = 0; s < 2; s++) begin
      last_rd[s] = '0;
      last_er[s] = 1'b0;
    end
    #2 rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < L1 + 2; i++) begin
      @(negedge clk);
      if (rv1 !== 1'b0) seen = 1'b1;
    end
    n_chk++;
    if (seen) $display("FAIL dropped_resp: got valid=1 after reset want 0"); else n_pass++;
    xfer(1, 1'b0, 32'h20, 3'b010, 32'h0, rd, er);
    n_chk++;
    if (rd !== d) $display("FAIL store_survives_reset: got %h want %h", rd, d); else n_pass++;
    gap(1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_store_load();
    test_byte();
    test_half();
    test_errors();
    test_random(0, 64, 300);
    test_random(1, D1, 200);
    test_back_to_back();
    test_reset_busy();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
